// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared SHA-1 constants, state encoding and round helper functions
//
// Purpose: single home for the SHA-1 initial value, round constants, the
// block-core FSM state type and the boolean round functions used by
// sha1_round and sha1_block_core.
// Ports: none (package).

package sha1_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam logic [31:0] H0_INIT = 32'h6745_2301;
  localparam logic [31:0] H1_INIT = 32'hefcd_ab89;
  localparam logic [31:0] H2_INIT = 32'h98ba_dcfe;
  localparam logic [31:0] H3_INIT = 32'h1032_5476;
  localparam logic [31:0] H4_INIT = 32'hc3d2_e1f0;

  localparam logic [31:0] K0 = 32'h5a82_7999;
  localparam logic [31:0] K1 = 32'h6ed9_eba1;
  localparam logic [31:0] K2 = 32'h8f1b_bcdc;
  localparam logic [31:0] K3 = 32'hca62_c1d6;

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] f_ch(input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
    return (b & c) | (~b & d);
  endfunction

  function automatic logic [31:0] f_parity(input logic [31:0] b, input logic [31:0] c,
                                           input logic [31:0] d);
    return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] f_maj(input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
    return (b & c) | (b & d) | (c & d);
  endfunction

endpackage

// File: rtl/sha1_round.sv
// rtl/sha1_round.sv - combinational single SHA-1 round with f/K selection
//
// Purpose: computes the next working variables a..e from the current ones,
// the schedule word wt and the round index t.
// Ports:
//   a, b, c, d, e  in  32  current working variables
//   wt             in  32  message schedule word for this round
//   t              in  7   round index 0..79, selects f and K
//   a_next..e_next out 32  working variables after this round

module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] wt,
  input  logic [6:0]  t,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next
);

  logic [31:0] f;
  logic [31:0] k;

  always_comb begin
    f = f_parity(b, c, d);
    k = K3;
    if (t < 7'd20) begin
      f = f_ch(b, c, d);
      k = K0;
    end else if (t < 7'd40) begin
      f = f_parity(b, c, d);
      k = K1;
    end else if (t < 7'd60) begin
      f = f_maj(b, c, d);
      k = K2;
    end
  end

  assign a_next = rotl(a, 5'd5) + f + e + k + wt;
  assign b_next = a;
  assign c_next = rotl(b, 5'd30);
  assign d_next = c;
  assign e_next = d;

endmodule

// File: rtl/sha1_block_core.sv
// rtl/sha1_block_core.sv - iterative SHA-1 compression core fed by the padded-word stream
//
// Purpose: collects 16 big-endian 32-bit words per block into a circular W
// buffer, runs 80 rounds (one per cycle), folds the result into H0..H4 and
// pulses sha_valid when the digest has been updated.
// Ports:
//   clk        in  1    clock
//   rst_n      in  1    synchronous active-low reset
//   restart    in  1    reload H with the IV (IDLE only)
//   start      in  1    data_in holds a valid block word this cycle
//   data_in    in  32   block word, W[0] first
//   sha_ready  out 1    core idle, may accept word 0 of a block
//   sha_valid  out 1    one-cycle pulse, digest updated
//   digest     out 160  {H0,H1,H2,H3,H4}

module sha1_block_core
  import sha1_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic         start,
  input  logic [31:0]  data_in,
  output logic         sha_ready,
  output logic         sha_valid,
  output logic [159:0] digest
);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [6:0]  t;
  logic [31:0] w_buf [16];
  logic [31:0] h0, h1, h2, h3, h4;
  logic [31:0] a, b, c, d, e;
  logic [31:0] a_n, b_n, c_n, d_n, e_n;
  logic [31:0] w_sched;
  logic [31:0] wt;
  logic [3:0]  i0, i3, i8, i14;
  logic        ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LOAD;
      S_LOAD:   if (start && cnt == 4'd15) state_next = S_ROUND;
      S_ROUND:  if (t == 7'd79) state_next = S_UPDATE;
      S_UPDATE: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // The 16-entry buffer is used circularly: for t>=16 the slot W[t&15]
  // still holds W[t-16] and is overwritten with the freshly expanded word.
  assign i0  = t[3:0];
  assign i3  = t[3:0] - 4'd3;
  assign i8  = t[3:0] - 4'd8;
  assign i14 = t[3:0] - 4'd14;
  assign w_sched = rotl(w_buf[i3] ^ w_buf[i8] ^ w_buf[i14] ^ w_buf[i0], 5'd1);
  assign wt      = (t < 7'd16) ? w_buf[i0] : w_sched;

  always_ff @(posedge clk) begin
    if (state == S_IDLE && start)
      w_buf[0] <= data_in;
    else if (state == S_LOAD && start)
      w_buf[cnt] <= data_in;
    else if (state == S_ROUND && t >= 7'd16)
      w_buf[i0] <= w_sched;
  end

  sha1_round u_round (
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .e      (e),
    .wt     (wt),
    .t      (t),
    .a_next (a_n),
    .b_next (b_n),
    .c_next (c_n),
    .d_next (d_n),
    .e_next (e_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      t       <= 7'd0;
      h0      <= H0_INIT;
      h1      <= H1_INIT;
      h2      <= H2_INIT;
      h3      <= H3_INIT;
      h4      <= H4_INIT;
      a       <= 32'd0;
      b       <= 32'd0;
      c       <= 32'd0;
      d       <= 32'd0;
      e       <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      // Registered so that the first cycle out of reset reports not-ready.
      ready_q <= (state_next == S_IDLE);
      case (state)
        S_IDLE: begin
          if (restart) begin
            h0 <= H0_INIT;
            h1 <= H1_INIT;
            h2 <= H2_INIT;
            h3 <= H3_INIT;
            h4 <= H4_INIT;
          end
          if (start) cnt <= 4'd1;
        end
        S_LOAD: begin
          if (start) begin
            if (cnt == 4'd15) begin
              cnt <= 4'd0;
              t   <= 7'd0;
              a   <= h0;
              b   <= h1;
              c   <= h2;
              d   <= h3;
              e   <= h4;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        S_ROUND: begin
          a <= a_n;
          b <= b_n;
          c <= c_n;
          d <= d_n;
          e <= e_n;
          t <= (t == 7'd79) ? 7'd0 : t + 7'd1;
        end
        S_UPDATE: begin
          h0 <= h0 + a;
          h1 <= h1 + b;
          h2 <= h2 + c;
          h3 <= h3 + d;
          h4 <= h4 + e;
        end
        default: begin
        end
      endcase
    end
  end

  assign sha_ready = ready_q;
  assign sha_valid = (state == S_DONE);
  assign digest    = {h0, h1, h2, h3, h4};

endmodule
